// File: rtl/fpcvt_ret_buf.sv
// Return buffer behind the FP-to-integer converter: a small FIFO of conversion results with
// credit-based issue permit, flush kill tracking and a sticky protocol error flag.
package fpcvt_ret_buf_pkg;
    localparam int unsigned RES_W = 65;
    localparam int unsigned TAG_W = 9;

    typedef struct packed {
        logic [RES_W-1:0] res;
        logic             alt;
        logic [TAG_W-1:0] tag;
    } ret_ent_t;
endpackage

module fpcvt_ret_buf
    import fpcvt_ret_buf_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CVT_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_cvt,
    input  logic                       cvt_vld,
    input  logic [RES_W-1:0]           cvt_res,
    input  logic                       cvt_alt,
    input  logic [TAG_W-1:0]           cvt_tag,
    input  logic                       flush,
    input  logic                       wb_stall,
    output logic                       wb_en,
    output logic [RES_W-1:0]           wb_data,
    output logic                       wb_alt,
    output logic [TAG_W-1:0]           wb_tag,
    output logic                       iss_ok,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = 32;

    ret_ent_t             mem_q [DEPTH];
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CVT_LAT-1:0]   live_q, live_d;
    logic [CVT_LAT-1:0]   kill_q, kill_d;
    logic                 err_q, err_d;

    logic                 full_c;
    logic                 pop_c;
    logic                 push_req_c;
    logic                 push_c;
    logic [OW-1:0]        inflight_c;

    // Credit: occupied slots plus conversions still in the converter pipe.
    always_comb begin
        inflight_c = '0;
        for (int unsigned i = 0; i < CVT_LAT; i++) begin
            inflight_c = inflight_c + OW'(live_q[i]);
        end
        iss_ok = (OW'(cnt_q) + inflight_c) < OW'(DEPTH);
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        full_c     = (cnt_q == CW'(DEPTH));
        pop_c      = (cnt_q != '0) && !wb_stall && !flush;
        push_req_c = cvt_vld && !kill_q[CVT_LAT-1] && !flush;
        push_c     = push_req_c && (!full_c || pop_c);
        live_d     = (live_q << 1) | CVT_LAT'(iss_cvt && !flush);
        kill_d     = kill_q << 1;

        // An issue in the flush cycle itself is already in the converter, so it is killed too.
        if (flush) begin
            live_d = '0;
            kill_d = ((live_q | kill_q) << 1) | CVT_LAT'(iss_cvt);
        end

        if ((push_req_c && full_c && !pop_c) || (iss_cvt && !iss_ok)) begin
            err_d = 1'b1;
        end

        if (pop_c) begin
            head_d = head_q + PW'(1);
        end
        if (push_c) begin
            tail_d = tail_q + PW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            live_q <= '0;
            kill_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            live_q <= live_d;
            kill_q <= kill_d;
            err_q  <= err_d;
        end
    end

    // Storage is written only on an accepted push, so a stalled head never changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[tail_q] <= '{res: cvt_res, alt: cvt_alt, tag: cvt_tag};
        end
    end

    assign wb_en   = (cnt_q != '0);
    assign wb_data = mem_q[head_q].res;
    assign wb_alt  = mem_q[head_q].alt;
    assign wb_tag  = mem_q[head_q].tag;
    assign cnt     = cnt_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fpcvt_ret_buf.sv
// Randomised bench for fpcvt_ret_buf: a queue-based model of the buffer and the converter pipe
// is advanced alongside the DUT and compared every cycle.
module tb_fpcvt_ret_buf;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CVT_LAT = 2;

    typedef struct {
        logic [64:0] res;
        logic        alt;
        logic [8:0]  tag;
    } ent_t;

    typedef struct {
        int unsigned due;
        bit          killed;
        ent_t        e;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_cvt = 1'b0;
    logic        cvt_vld = 1'b0;
    logic [64:0] cvt_res = '0;
    logic        cvt_alt = 1'b0;
    logic [8:0]  cvt_tag = '0;
    logic        flush = 1'b0;
    logic        wb_stall = 1'b0;
    logic        wb_en;
    logic [64:0] wb_data;
    logic        wb_alt;
    logic [8:0]  wb_tag;
    logic        iss_ok;
    logic [2:0]  cnt;
    logic        err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    logic [8:0]  tag_ctr = '0;

    ent_t  q[$];
    pend_t pend[$];
    bit    m_err = 1'b0;

    fpcvt_ret_buf #(.DEPTH(DEPTH), .CVT_LAT(CVT_LAT)) dut (
        .clk(clk), .rst(rst), .iss_cvt(iss_cvt), .cvt_vld(cvt_vld), .cvt_res(cvt_res),
        .cvt_alt(cvt_alt), .cvt_tag(cvt_tag), .flush(flush), .wb_stall(wb_stall),
        .wb_en(wb_en), .wb_data(wb_data), .wb_alt(wb_alt), .wb_tag(wb_tag),
        .iss_ok(iss_ok), .cnt(cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [64:0] rnd_res();
        return {1'($urandom), $urandom, $urandom};
    endfunction

    // Issue permit: buffered entries plus unkilled conversions still in the pipe.
    function automatic bit model_ok();
        int unsigned n;
        n = q.size();
        foreach (pend[i]) if (!pend[i].killed) n++;
        return n < DEPTH;
    endfunction

    // One clock cycle: check pre-edge outputs, drive inputs, advance the model. Enters/leaves at negedge.
    task automatic step(input bit iss, input bit fl, input bit st, input bit inj,
                        input logic [64:0] r, input logic a, input logic [8:0] t);
        bit    ok, vld, vk, pop, was_full;
        ent_t  ve;
        pend_t p;
        ok = model_ok();
        chk("wb_en", 65'(wb_en), 65'(q.size() != 0));
        if (q.size() != 0) begin
            chk("wb_data", wb_data, q[0].res);
            chk("wb_alt", 65'(wb_alt), 65'(q[0].alt));
            chk("wb_tag", 65'(wb_tag), 65'(q[0].tag));
        end
        chk("cnt", 65'(cnt), 65'(q.size()));
        chk("err", 65'(err), 65'(m_err));
        chk("iss_ok", 65'(iss_ok), 65'(ok));

        vld = 1'b0;
        vk  = 1'b0;
        ve.res = rnd_res();
        ve.alt = 1'($urandom);
        ve.tag = 9'($urandom);
        if (inj) begin
            vld = 1'b1;
            ve.res = r;
            ve.alt = a;
            ve.tag = t;
        end else if (pend.size() != 0 && pend[0].due == cyc) begin
            vld = 1'b1;
            vk  = pend[0].killed;
            ve  = pend[0].e;
            pend.delete(0);
        end

        iss_cvt  = iss;
        flush    = fl;
        wb_stall = st;
        cvt_vld  = vld;
        cvt_res  = ve.res;
        cvt_alt  = ve.alt;
        cvt_tag  = ve.tag;

        if (iss && !ok) m_err = 1'b1;
        was_full = (q.size() == DEPTH);
        pop = (q.size() != 0) && !st && !fl;
        if (fl) begin
            q.delete();
            foreach (pend[i]) pend[i].killed = 1'b1;
        end else begin
            if (pop) q.delete(0);
            if (vld && !vk) begin
                if (was_full && !pop) m_err = 1'b1;
                else q.push_back(ve);
            end
        end
        if (iss) begin
            p.due    = cyc + CVT_LAT;
            p.killed = fl;
            p.e.res  = r;
            p.e.alt  = a;
            p.e.tag  = t;
            pend.push_back(p);
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n, input bit st);
        repeat (n) step(1'b0, 1'b0, st, 1'b0, rnd_res(), 1'b0, 9'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iss_cvt = 1'b0; cvt_vld = 1'b0; flush = 1'b0; wb_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wb_en", 65'(wb_en), 65'(0));
        chk("rst_wb_data", wb_data, 65'(0));
        chk("rst_wb_alt", 65'(wb_alt), 65'(0));
        chk("rst_wb_tag", 65'(wb_tag), 65'(0));
        chk("rst_cnt", 65'(cnt), 65'(0));
        chk("rst_err", 65'(err), 65'(0));
        chk("rst_iss_ok", 65'(iss_ok), 65'(1));
        rst = 1'b0;
        q.delete();
        pend.delete();
        m_err = 1'b0;
    endtask

    initial begin
        int unsigned issued;
        @(posedge clk);
        do_reset();

        // Single op
        step(1'b1, 1'b0, 1'b0, 1'b0, 65'h1_0000_0000_0000_002A, 1'b0, 9'h05);
        idle(2, 1'b0);
        chk("single_en", 65'(wb_en), 65'(1));
        chk("single_data", wb_data, 65'h1_0000_0000_0000_002A);
        chk("single_tag", 65'(wb_tag), 65'(9'h05));
        idle(1, 1'b0);
        chk("single_done", 65'(wb_en), 65'(0));
        idle(2, 1'b0);

        // Fill under stall, then drain in order
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, rnd_res(), 1'($urandom), 9'(i));
        chk("fill_ok", 65'(iss_ok), 65'(0));
        idle(2, 1'b1);
        chk("fill_cnt", 65'(cnt), 65'(4));
        chk("fill_err", 65'(err), 65'(0));
        for (int i = 0; i < 4; i++) begin
            chk("drain_tag", 65'(wb_tag), 65'(i));
            step(1'b0, 1'b0, 1'b0, 1'b0, rnd_res(), 1'b0, 9'h0);
            if (i == 0) chk("drain_ok", 65'(iss_ok), 65'(1));
        end
        idle(2, 1'b0);

        // Full buffer with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, rnd_res(), 1'b0, 9'(10 + i));
        idle(2, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, rnd_res(), 1'b1, 9'h077);
        chk("pp_cnt", 65'(cnt), 65'(4));
        chk("pp_err", 65'(err), 65'(0));
        chk("pp_head", 65'(wb_tag), 65'(11));
        idle(6, 1'b0);

        // Flush with two conversions in flight
        step(1'b1, 1'b0, 1'b0, 1'b0, rnd_res(), 1'b0, 9'h030);
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd_res(), 1'b0, 9'h031);
        chk("fl_ok", 65'(iss_ok), 65'(1));
        for (int i = 0; i < 3; i++) begin
            chk("fl_en", 65'(wb_en), 65'(0));
            chk("fl_cnt", 65'(cnt), 65'(0));
            idle(1, 1'b0);
        end

        // Overflow: forced result into a full, stalled buffer
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, rnd_res(), 1'b0, 9'(20 + i));
        idle(2, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, rnd_res(), 1'b1, 9'h1FF);
        chk("ovf_err", 65'(err), 65'(1));
        chk("ovf_cnt", 65'(cnt), 65'(4));
        chk("ovf_head", 65'(wb_tag), 65'(20));
        idle(2, 1'b1);
        chk("ovf_sticky", 65'(err), 65'(1));
        do_reset();

        // Pointer wrap: 11 ops with random stall
        issued = 0;
        tag_ctr = 9'h100;
        while (issued < 11) begin
            if (model_ok() && ($urandom_range(0, 99) < 70)) begin
                step(1'b1, 1'b0, ($urandom_range(0, 99) < 50), 1'b0, rnd_res(), 1'($urandom), tag_ctr);
                tag_ctr++;
                issued++;
            end else begin
                step(1'b0, 1'b0, ($urandom_range(0, 99) < 50), 1'b0, rnd_res(), 1'b0, 9'h0);
            end
        end
        idle(12, 1'b0);
        chk("wrap_empty", 65'(wb_en), 65'(0));

        // Long random run with occasional flushes
        for (int c = 0; c < 2000; c++) begin
            bit iss, fl, st;
            iss = model_ok() && ($urandom_range(0, 99) < 60);
            fl  = ($urandom_range(0, 99) < 3);
            st  = ($urandom_range(0, 99) < 40);
            step(iss, fl, st, 1'b0, rnd_res(), 1'($urandom), tag_ctr);
            if (iss) tag_ctr++;
        end
        idle(10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
